// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
// Holds the FSM state enum, parity selectors and the baud divisor helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    localparam int PARITY_ODD  = 0;
    localparam int PARITY_EVEN = 1;

    // clk cycles per serial bit, truncated
    function automatic int baud_ticks(
        input int sys_clk_freq,
        input int baud_rate
    );
        return sys_clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Clear-able down-counter that paces one serial bit period.
// Ports: clk, reset (async, high), clear_i (reload), bit_tick_o (last cycle
// of a bit period), pre_tick_o (second-to-last cycle of a bit period).
module uart_baud_gen #(
    parameter int TICKS = 1085
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    output logic bit_tick_o,
    output logic pre_tick_o
);

    localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TICKS - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q - ONE;
        if (clear_i || (cnt_q == '0)) begin
            cnt_d = LOAD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick_o = (cnt_q == '0);
    assign pre_tick_o = (cnt_q == ONE);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter with CTS flow control, optional parity, 1 or 2 stop bits.
// Ports: clk, reset (async, high), tx_data/tx_valid/tx_ready (word handshake),
// CTS (async flow control in), TX (serial out), busy, tx_done (1-cycle pulse).
module uart_tx
    import uart_pkg::*;
#(
    parameter int UART_SIZE     = 8,
    parameter int BAUD_RATE     = 115200,
    parameter int SYS_CLK_FREQ  = 125000000,
    parameter int PARITY_ENABLE = 0,
    parameter int PARITY_TYPE   = 0,
    parameter int STOP_BITS     = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [UART_SIZE-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic                 CTS,
    output logic                 TX,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int BAUD_TICKS = baud_ticks(SYS_CLK_FREQ, BAUD_RATE);
    localparam int BCW = $clog2(UART_SIZE + 1);
    localparam logic [BCW-1:0] LAST_DATA = BCW'(UART_SIZE - 1);
    localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);
    localparam logic [BCW-1:0] ONE       = BCW'(1);

    uart_tx_state_t       state_q, state_d;
    logic [UART_SIZE-1:0] shift_q, shift_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 cts_meta_q, cts_s_q;
    logic                 accept;
    logic                 data_par;
    logic                 bit_tick;
    logic                 pre_tick;

    // parity is taken from the word at capture; the shifter consumes it later
    assign data_par = (PARITY_TYPE == PARITY_ODD) ? ~^tx_data : ^tx_data;

    assign tx_ready = (state_q == IDLE) && cts_s_q;
    assign accept   = tx_valid && tx_ready;

    uart_baud_gen #(
        .TICKS(BAUD_TICKS)
    ) u_baud (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (state_q == IDLE),
        .bit_tick_o(bit_tick),
        .pre_tick_o(pre_tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = START;
                    shift_d   = tx_data;
                    par_d     = data_par;
                    bit_cnt_d = '0;
                    tx_d      = 1'b0;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        if (PARITY_ENABLE != 0) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + ONE;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_d[0];
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                // leave one cycle early: the first IDLE cycle is the last
                // stop cycle, so a word accepted there starts with no gap
                if ((bit_cnt_q == LAST_STOP) && pre_tick) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    done_d    = 1'b1;
                end else if (bit_tick) begin
                    bit_cnt_d = bit_cnt_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            cts_meta_q <= 1'b0;
            cts_s_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
            cts_meta_q <= CTS;
            cts_s_q    <= cts_meta_q;
        end
    end

    assign TX      = tx_q;
    assign busy    = (state_q != IDLE);
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: default, odd/even parity and 2-stop instances.
// Expected line sequences are written out by hand per scenario.
module tb_uart_tx;

    localparam int BT = 1085;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       CTS = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       v0 = 1'b0, vp = 1'b0, v3 = 1'b0;
    logic       r0, t0, b0, d0;
    logic       r1, t1, b1, d1;
    logic       r2, t2, b2, d2;
    logic       r3, t3, b3, d3;

    int total = 0;
    int bad = 0;
    int sel = 0;

    logic mon_tx, mon_rdy, mon_busy, mon_done;

    bit txl [0:13100];
    bit dnl [0:13100];
    bit bsl [0:13100];
    bit p2l [0:13100];

    always #5 clk = ~clk;

    uart_tx u0 (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(v0),
        .tx_ready(r0), .CTS(CTS), .TX(t0), .busy(b0), .tx_done(d0)
    );
    uart_tx #(.PARITY_ENABLE(1), .PARITY_TYPE(0)) u1 (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(vp),
        .tx_ready(r1), .CTS(CTS), .TX(t1), .busy(b1), .tx_done(d1)
    );
    uart_tx #(.PARITY_ENABLE(1), .PARITY_TYPE(1)) u2 (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(vp),
        .tx_ready(r2), .CTS(CTS), .TX(t2), .busy(b2), .tx_done(d2)
    );
    uart_tx #(.STOP_BITS(2)) u3 (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(v3),
        .tx_ready(r3), .CTS(CTS), .TX(t3), .busy(b3), .tx_done(d3)
    );

    always_comb begin
        mon_tx = t0; mon_rdy = r0; mon_busy = b0; mon_done = d0;
        case (sel)
            1: begin mon_tx = t1; mon_rdy = r1; mon_busy = b1; mon_done = d1; end
            3: begin mon_tx = t3; mon_rdy = r3; mon_busy = b3; mon_done = d3; end
            default: ;
        endcase
    end

    task automatic set_valid(input int s, input logic v);
        case (s)
            1: vp = v;
            3: v3 = v;
            default: v0 = v;
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // offers a word; returns once the accepting edge has passed (+1)
    task automatic start_frame(input int s, input logic [7:0] d, output bit ok);
        @(negedge clk);
        tx_data = d;
        set_valid(s, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (mon_rdy === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(posedge clk); #1;
        set_valid(s, 1'b0);
    endtask

    // records n negedge samples; index 0 is the first cycle after acceptance
    task automatic capture(input int n, input int poke);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            txl[i] = mon_tx; dnl[i] = mon_done;
            bsl[i] = mon_busy; p2l[i] = t2;
            if (i == poke) begin CTS = 1'b0; tx_data = 8'h0F; v0 = 1'b1; end
        end
    endtask

    function automatic int miss(input int from, input int len, input bit v, input bit alt);
        int m = 0;
        for (int i = from; i < from + len; i++) begin
            if ((alt ? p2l[i] : txl[i]) !== v) m++;
        end
        return m;
    endfunction

    function automatic int first_done(input int n);
        for (int i = 0; i < n; i++) if (dnl[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        reset = 1'b1; CTS = 1'b1;
        @(posedge clk); @(negedge clk);
        total++; if ({t0, t1, t2, t3} !== 4'hF) begin bad++;
            $display("FAIL rst_tx: got %b want 1111", {t0, t1, t2, t3}); end
        total++; if ({r0, r1, r2, r3} !== 4'h0) begin bad++;
            $display("FAIL rst_ready: got %b want 0000", {r0, r1, r2, r3}); end
        total++; if ({b0, b1, b2, b3} !== 4'h0) begin bad++;
            $display("FAIL rst_busy: got %b want 0000", {b0, b1, b2, b3}); end
        total++; if ({d0, d1, d2, d3} !== 4'h0) begin bad++;
            $display("FAIL rst_done: got %b want 0000", {d0, d1, d2, d3}); end
        reset = 1'b0;
        @(negedge clk);
        total++; if (r0 !== 1'b0) begin bad++;
            $display("FAIL rst_ready_early: got %b want 0", r0); end
        @(negedge clk);
        total++; if (r0 !== 1'b1) begin bad++;
            $display("FAIL rst_ready_late: got %b want 1", r0); end
    endtask

    task automatic test_frame();
        bit e [10] = '{0, 1, 1, 0, 0, 1, 0, 1, 0, 1};
        bit ok;
        int m, fd;
        sel = 0;
        start_frame(0, 8'h53, ok);
        total++; if (!ok) begin bad++;
            $display("FAIL frame_accept: ready %b want 1", ok); end
        capture(10851, -1);
        for (int b = 0; b < 10; b++) begin
            m = miss(b * BT, BT, e[b], 1'b0);
            total++; if (m !== 0) begin bad++;
                $display("FAIL frame_bit%0d: %0d cycles differ from %0d", b, m, e[b]); end
        end
        fd = first_done(10851);
        total++; if (fd !== 10849) begin bad++;
            $display("FAIL frame_done: at cycle %0d want 10849", fd); end
        total++; if (dnl[10850] !== 1'b0) begin bad++;
            $display("FAIL frame_done_width: got %b want 0", dnl[10850]); end
        total++; if ({bsl[0], bsl[10848], bsl[10849]} !== 3'b110) begin bad++;
            $display("FAIL frame_busy: got %b want 110", {bsl[0], bsl[10848], bsl[10849]}); end
    endtask

    task automatic test_parity();
        bit e [11] = '{0, 1, 1, 0, 0, 1, 0, 1, 0, 1, 1};
        bit ok;
        int m, fd;
        sel = 1;
        start_frame(1, 8'h53, ok);
        total++; if (!ok) begin bad++;
            $display("FAIL par_accept: ready %b want 1", ok); end
        capture(11936, -1);
        m = 0;
        for (int b = 0; b < 11; b++) m += miss(b * BT, BT, e[b], 1'b0);
        total++; if (m !== 0) begin bad++;
            $display("FAIL par_odd_frame: %0d cycles wrong want 0", m); end
        m = miss(9 * BT, BT, 1'b1, 1'b0);
        total++; if (m !== 0) begin bad++;
            $display("FAIL par_odd_bit: %0d cycles not 1 want 0", m); end
        m = miss(9 * BT, BT, 1'b0, 1'b1);
        total++; if (m !== 0) begin bad++;
            $display("FAIL par_even_bit: %0d cycles not 0 want 0", m); end
        m = miss(10 * BT, BT - 1, 1'b1, 1'b1);
        total++; if (m !== 0) begin bad++;
            $display("FAIL par_even_stop: %0d cycles not 1 want 0", m); end
        fd = first_done(11936);
        total++; if (fd !== 11934) begin bad++;
            $display("FAIL par_done: at cycle %0d want 11934", fd); end
    endtask

    task automatic test_cts_gate();
        int errs = 0;
        int acc = 0;
        sel = 0;
        CTS = 1'b0;
        repeat (4) @(negedge clk);
        tx_data = 8'hA5; v0 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (t0 !== 1'b1 || r0 !== 1'b0 || b0 !== 1'b0) errs++;
        end
        total++; if (errs !== 0) begin bad++;
            $display("FAIL cts_block: %0d bad cycles want 0", errs); end
        CTS = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (b0 === 1'b1) begin acc = k; break; end
        end
        v0 = 1'b0;
        total++; if (acc == 0 || acc > 3) begin bad++;
            $display("FAIL cts_accept: after %0d cycles want 1..3", acc); end
        @(negedge clk);
        total++; if (t0 !== 1'b0) begin bad++;
            $display("FAIL cts_start: tx %b want 0", t0); end
        do_reset();
    endtask

    task automatic test_back_to_back();
        bit e [9] = '{0, 1, 0, 1, 0, 0, 1, 0, 1};
        bit ok = 1'b0;
        int m, fd;
        sel = 3;
        @(negedge clk);
        tx_data = 8'hA5; v3 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (r3 === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(posedge clk); #1;
        tx_data = 8'h3C;
        capture(13021, -1);
        v3 = 1'b0;
        total++; if (!ok) begin bad++;
            $display("FAIL b2b_accept: ready %b want 1", ok); end
        m = 0;
        for (int b = 0; b < 9; b++) m += miss(b * BT, BT, e[b], 1'b0);
        total++; if (m !== 0) begin bad++;
            $display("FAIL b2b_data: %0d cycles wrong want 0", m); end
        m = miss(9 * BT, 2170, 1'b1, 1'b0);
        total++; if (m !== 0) begin bad++;
            $display("FAIL b2b_stop: %0d of 2170 stop cycles not 1", m); end
        m = miss(11935, BT, 1'b0, 1'b0);
        total++; if (m !== 0) begin bad++;
            $display("FAIL b2b_start2: %0d cycles not 0 want 0", m); end
        fd = first_done(13021);
        total++; if (fd !== 11934) begin bad++;
            $display("FAIL b2b_done: at cycle %0d want 11934", fd); end
        total++; if ({bsl[11934], bsl[11935]} !== 2'b01) begin bad++;
            $display("FAIL b2b_busy: got %b want 01", {bsl[11934], bsl[11935]}); end
        do_reset();
    endtask

    task automatic test_reset_mid();
        bit e [10] = '{0, 1, 1, 0, 0, 1, 0, 1, 0, 1};
        bit ok;
        int m, fd;
        int dn = 0;
        sel = 0;
        start_frame(0, 8'h53, ok);
        capture(4 * BT + 500, -1);
        total++; if (t0 !== 1'b0) begin bad++;
            $display("FAIL rmid_pre: tx %b want 0", t0); end
        #2; reset = 1'b1; #1;
        total++; if (t0 !== 1'b1 || b0 !== 1'b0) begin bad++;
            $display("FAIL rmid_async: tx/busy %b%b want 10", t0, b0); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 3) reset = 1'b0;
            if (d0 !== 1'b0) dn++;
        end
        total++; if (dn !== 0) begin bad++;
            $display("FAIL rmid_nodone: %0d pulses want 0", dn); end
        start_frame(0, 8'h53, ok);
        total++; if (!ok) begin bad++;
            $display("FAIL rmid_accept: ready %b want 1", ok); end
        capture(10851, -1);
        m = 0;
        for (int b = 0; b < 10; b++) m += miss(b * BT, BT, e[b], 1'b0);
        total++; if (m !== 0) begin bad++;
            $display("FAIL rmid_frame: %0d cycles wrong want 0", m); end
        fd = first_done(10851);
        total++; if (fd !== 10849) begin bad++;
            $display("FAIL rmid_done: at cycle %0d want 10849", fd); end
    endtask

    task automatic test_cts_drop();
        bit e [10] = '{0, 1, 1, 0, 0, 1, 0, 1, 0, 1};
        bit ok;
        int m, fd;
        int errs = 0;
        int acc = 0;
        sel = 0;
        CTS = 1'b1;
        start_frame(0, 8'h53, ok);
        capture(10851, 3000);
        m = 0;
        for (int b = 0; b < 10; b++) m += miss(b * BT, BT, e[b], 1'b0);
        total++; if (m !== 0) begin bad++;
            $display("FAIL drop_frame: %0d cycles wrong want 0", m); end
        fd = first_done(10851);
        total++; if (fd !== 10849) begin bad++;
            $display("FAIL drop_done: at cycle %0d want 10849", fd); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (r0 !== 1'b0 || b0 !== 1'b0 || t0 !== 1'b1) errs++;
        end
        total++; if (errs !== 0) begin bad++;
            $display("FAIL drop_hold: %0d bad cycles want 0", errs); end
        CTS = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (b0 === 1'b1) begin acc = k; break; end
        end
        v0 = 1'b0;
        total++; if (acc == 0 || acc > 3) begin bad++;
            $display("FAIL drop_resume: after %0d cycles want 1..3", acc); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_frame();
        test_parity();
        test_cts_gate();
        test_back_to_back();
        test_reset_mid();
        test_cts_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
